// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and defaults for the interrupt source unit
//
// Purpose: controller state encoding and the default source count, shared by
// the interface, the priority encoder and the top level.
package irq_pkg;

    localparam int N_SRC_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_source_unit_if.sv
// rtl/irq_source_unit_if.sv - source/mask/request/return signal bundle
//
// Purpose: groups every non-clock signal of irq_source_unit.
// Ports (slave = unit side):
//   src_i      in   N_SRC  interrupt lines, rising edge raises an event
//   en_i       in   N_SRC  per-source enable mask
//   irq_ret_i  in   1      handler-returned strobe from the core
//   irq_req_o  out  1      request to the core
//   irq_id_o   out  ID_W   index being requested/served
//   pending_o  out  N_SRC  pending register
//   busy_o     out  1      source in service
import irq_pkg::*;

interface irq_source_unit_if #(
    parameter int N_SRC = N_SRC_DEFAULT,
    parameter int ID_W  = $clog2(N_SRC)
);
    logic [N_SRC-1:0] src_i;
    logic [N_SRC-1:0] en_i;
    logic             irq_ret_i;
    logic             irq_req_o;
    logic [ID_W-1:0]  irq_id_o;
    logic [N_SRC-1:0] pending_o;
    logic             busy_o;

    modport slave (
        input  src_i, en_i, irq_ret_i,
        output irq_req_o, irq_id_o, pending_o, busy_o
    );

    modport master (
        output src_i, en_i, irq_ret_i,
        input  irq_req_o, irq_id_o, pending_o, busy_o
    );
endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins combinational priority encoder
//
// Purpose: returns the index of the lowest set request bit and a valid flag.
// Ports:
//   req  in   W      request vector
//   idx  out  IDX_W  index of lowest set bit (0 when none set)
//   vld  out  1      any request bit set
import irq_pkg::*;

module irq_prio_enc #(
    parameter int W     = N_SRC_DEFAULT,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign vld = |req;

endmodule

// File: rtl/irq_source_unit.sv
// rtl/irq_source_unit.sv - edge-latched, fixed-priority interrupt source unit
//
// Purpose: latches rising edges of N_SRC lines into a pending register,
// picks the lowest enabled pending index, holds a request to the core until
// the return strobe, clears the served bit and forces one idle request cycle.
// Ports:
//   clk_i  in  1  system clock
//   rst_i  in  1  asynchronous active-low reset
//   bus    slave modport of irq_source_unit_if (sources, mask, handshake)
import irq_pkg::*;

module irq_source_unit #(
    parameter int N_SRC = N_SRC_DEFAULT,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    irq_source_unit_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_GAP  = GAP;

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] cand;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  win_id;
    logic             win_vld;
    logic             req_q;

    assign rise = bus.src_i & ~src_q;
    assign cand = pending & bus.en_i;

    // Only a return seen while serving clears anything; strays are ignored.
    always_comb begin
        clr = '0;
        if (state == ST_REQ && bus.irq_ret_i) begin
            clr[id_q] = 1'b1;
        end
    end

    irq_prio_enc #(
        .W     (N_SRC),
        .IDX_W (ID_W)
    ) u_prio_enc (
        .req (cand),
        .idx (win_id),
        .vld (win_vld)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (win_vld)       state_nxt = ST_REQ;
            ST_REQ:  if (bus.irq_ret_i) state_nxt = ST_GAP;
            ST_GAP:                     state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            src_q   <= '0;
            pending <= '0;
            state   <= ST_IDLE;
            id_q    <= '0;
            req_q   <= 1'b0;
        end else begin
            src_q   <= bus.src_i;
            // Set after clear: an edge in the return cycle keeps the bit.
            pending <= (pending & ~clr) | rise;
            state   <= state_nxt;
            if (state == ST_IDLE && win_vld) begin
                id_q <= win_id;
            end
            // Request flop mirrors the next state so the output has no
            // decode logic between register and pin.
            req_q   <= (state_nxt == ST_REQ);
        end
    end

    assign bus.irq_req_o = req_q;
    assign bus.busy_o    = req_q;
    assign bus.irq_id_o  = id_q;
    assign bus.pending_o = pending;

endmodule

// File: tb/tb_irq_source_unit.sv
// tb/tb_irq_source_unit.sv - self-checking bench for irq_source_unit
module tb_irq_source_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] src;
    logic [15:0] en;
    logic        ret;

    int checks = 0;
    int fails  = 0;

    // reference model: pending set, service phase (0 idle, 1 serving, 2 gap)
    logic [15:0] m_src_q;
    logic [15:0] m_pend;
    int          m_phase;
    int          m_id;

    always #5 clk = ~clk;

    irq_source_unit_if #(.N_SRC(16), .ID_W(4)) bus ();

    assign bus.src_i     = src;
    assign bus.en_i      = en;
    assign bus.irq_ret_i = ret;

    irq_source_unit #(.N_SRC(16), .ID_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    task automatic model_clear();
        m_src_q = '0;
        m_pend  = '0;
        m_phase = 0;
        m_id    = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied,
    // then let the DUT take the same edge and settle.
    task automatic tick();
        logic [15:0] rise;
        logic [15:0] cand;
        int          nphase;
        int          nid;
        rise   = src & ~m_src_q;
        cand   = m_pend & en;
        nphase = m_phase;
        nid    = m_id;
        if (m_phase == 0) begin
            if (cand != 0) begin
                nid    = $clog2(cand & (~cand + 16'd1));
                nphase = 1;
            end
        end else if (m_phase == 1) begin
            if (ret) begin
                nphase = 2;
                m_pend[m_id] = 1'b0;
            end
        end else begin
            nphase = 0;
        end
        m_pend  = m_pend | rise;
        m_src_q = src;
        m_phase = nphase;
        m_id    = nid;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src   = '0;
        en    = 16'hFFFF;
        ret   = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        src   = 16'hFFFF;
        en    = 16'hFFFF;
        ret   = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.irq_req_o, bus.busy_o, bus.irq_id_o, bus.pending_o} !== 22'd0) begin
            fails++;
            $display("FAIL reset_hold: got req=%b busy=%b id=%0d pend=%h, want all 0",
                     bus.irq_req_o, bus.busy_o, bus.irq_id_o, bus.pending_o);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.pending_o !== 16'hFFFF || bus.irq_req_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_pend: got pend=%h req=%b, want pend=ffff req=0",
                     bus.pending_o, bus.irq_req_o);
        end
        tick();
        checks++;
        if (bus.irq_req_o !== 1'b1 || bus.irq_id_o !== 4'd0 || bus.busy_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_req: got req=%b id=%0d busy=%b, want req=1 id=0 busy=1",
                     bus.irq_req_o, bus.irq_id_o, bus.busy_o);
        end
    endtask

    task automatic test_single_source();
        do_reset();
        src = 16'h0020;
        tick();
        src = '0;
        checks++;
        if (bus.pending_o !== 16'h0020 || bus.irq_req_o !== 1'b0) begin
            fails++;
            $display("FAIL single_pend: got pend=%h req=%b, want pend=0020 req=0",
                     bus.pending_o, bus.irq_req_o);
        end
        tick();
        checks++;
        if (bus.irq_req_o !== 1'b1 || bus.irq_id_o !== 4'd5) begin
            fails++;
            $display("FAIL single_req: got req=%b id=%0d, want req=1 id=5",
                     bus.irq_req_o, bus.irq_id_o);
        end
        repeat (3) tick();
        checks++;
        if (bus.irq_req_o !== 1'b1 || bus.irq_id_o !== 4'd5) begin
            fails++;
            $display("FAIL single_hold: got req=%b id=%0d, want req=1 id=5",
                     bus.irq_req_o, bus.irq_id_o);
        end
        ret = 1'b1;
        tick();
        ret = 1'b0;
        checks++;
        if (bus.pending_o !== 16'h0000 || bus.irq_req_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            fails++;
            $display("FAIL single_ret: got pend=%h req=%b busy=%b, want pend=0000 req=0 busy=0",
                     bus.pending_o, bus.irq_req_o, bus.busy_o);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.irq_req_o !== 1'b0) begin
                fails++;
                $display("FAIL single_quiet: cycle %0d got req=%b, want 0", k, bus.irq_req_o);
            end
        end
    endtask

    task automatic test_priority();
        int exp_ids [3] = '{3, 1, 9};
        int waited;
        do_reset();
        src = 16'h0208;
        tick();
        src = '0;
        for (int s = 0; s < 3; s++) begin
            waited = 0;
            while (bus.irq_req_o !== 1'b1 && waited < 8) begin
                tick();
                waited++;
            end
            checks++;
            if (bus.irq_req_o !== 1'b1 || bus.irq_id_o !== 4'(exp_ids[s])) begin
                fails++;
                $display("FAIL prio_order[%0d]: got req=%b id=%0d, want req=1 id=%0d",
                         s, bus.irq_req_o, bus.irq_id_o, exp_ids[s]);
            end
            if (s == 0) begin
                src = 16'h0002;
                tick();
                src = '0;
                tick();
                checks++;
                if (bus.irq_id_o !== 4'd3 || bus.pending_o !== 16'h020A) begin
                    fails++;
                    $display("FAIL prio_no_preempt: got id=%0d pend=%h, want id=3 pend=020a",
                             bus.irq_id_o, bus.pending_o);
                end
            end
            ret = 1'b1;
            tick();
            ret = 1'b0;
            checks++;
            if (bus.irq_req_o !== 1'b0) begin
                fails++;
                $display("FAIL prio_gap[%0d]: got req=%b, want 0", s, bus.irq_req_o);
            end
        end
    endtask

    task automatic test_mask();
        do_reset();
        en  = 16'hFFFE;
        src = 16'h0001;
        tick();
        src = '0;
        repeat (3) tick();
        checks++;
        if (bus.pending_o !== 16'h0001 || bus.irq_req_o !== 1'b0) begin
            fails++;
            $display("FAIL mask_hold: got pend=%h req=%b, want pend=0001 req=0",
                     bus.pending_o, bus.irq_req_o);
        end
        en = 16'hFFFF;
        tick();
        checks++;
        if (bus.irq_req_o !== 1'b1 || bus.irq_id_o !== 4'd0) begin
            fails++;
            $display("FAIL mask_unmask: got req=%b id=%0d, want req=1 id=0",
                     bus.irq_req_o, bus.irq_id_o);
        end
        en = 16'hFFFE;
        repeat (2) tick();
        checks++;
        if (bus.irq_req_o !== 1'b1 || bus.irq_id_o !== 4'd0) begin
            fails++;
            $display("FAIL mask_no_abort: got req=%b id=%0d, want req=1 id=0",
                     bus.irq_req_o, bus.irq_id_o);
        end
        ret = 1'b1;
        tick();
        ret = 1'b0;
        en  = 16'hFFFF;
    endtask

    task automatic test_set_clear();
        do_reset();
        src = 16'h0010;
        tick();
        src = '0;
        tick();
        checks++;
        if (bus.irq_req_o !== 1'b1 || bus.irq_id_o !== 4'd4) begin
            fails++;
            $display("FAIL setclr_req: got req=%b id=%0d, want req=1 id=4",
                     bus.irq_req_o, bus.irq_id_o);
        end
        src = 16'h0010;
        ret = 1'b1;
        tick();
        src = '0;
        ret = 1'b0;
        checks++;
        if (bus.pending_o !== 16'h0010 || bus.irq_req_o !== 1'b0) begin
            fails++;
            $display("FAIL setclr_keep: got pend=%h req=%b, want pend=0010 req=0",
                     bus.pending_o, bus.irq_req_o);
        end
        repeat (2) tick();
        checks++;
        if (bus.irq_req_o !== 1'b1 || bus.irq_id_o !== 4'd4) begin
            fails++;
            $display("FAIL setclr_rereq: got req=%b id=%0d, want req=1 id=4",
                     bus.irq_req_o, bus.irq_id_o);
        end
        ret = 1'b1;
        tick();
        tick();
        tick();
        ret = 1'b0;
        checks++;
        if (bus.pending_o !== 16'h0000 || bus.irq_req_o !== 1'b0 || bus.irq_id_o !== 4'd4) begin
            fails++;
            $display("FAIL stray_ret: got pend=%h req=%b id=%0d, want pend=0000 req=0 id=4",
                     bus.pending_o, bus.irq_req_o, bus.irq_id_o);
        end
    endtask

    task automatic test_reset_mid_service();
        do_reset();
        src = 16'h0080;
        tick();
        src = 16'h0004;
        tick();
        src = '0;
        checks++;
        if (bus.irq_req_o !== 1'b1 || bus.pending_o !== 16'h0084) begin
            fails++;
            $display("FAIL midrst_pre: got req=%b pend=%h, want req=1 pend=0084",
                     bus.irq_req_o, bus.pending_o);
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({bus.irq_req_o, bus.busy_o, bus.irq_id_o, bus.pending_o} !== 22'd0) begin
            fails++;
            $display("FAIL midrst_async: got req=%b busy=%b id=%0d pend=%h, want all 0",
                     bus.irq_req_o, bus.busy_o, bus.irq_id_o, bus.pending_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            r   = $urandom & $urandom & $urandom;
            src = r[15:0];
            r   = $urandom & $urandom;
            en  = ~r[15:0];
            if (m_phase == 1)
                ret = ($urandom_range(0, 3) == 0);
            else
                ret = ($urandom_range(0, 7) == 0);
            tick();
            checks++;
            if ({bus.irq_req_o, bus.busy_o, bus.irq_id_o, bus.pending_o} !==
                {(m_phase == 1), (m_phase == 1), 4'(m_id), m_pend}) begin
                fails++;
                $display("FAIL random[%0d]: got req=%b busy=%b id=%0d pend=%h, want req=%b id=%0d pend=%h",
                         c, bus.irq_req_o, bus.busy_o, bus.irq_id_o, bus.pending_o,
                         (m_phase == 1), m_id, m_pend);
            end
        end
        ret = 1'b0;
        src = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        src   = '0;
        en    = 16'hFFFF;
        ret   = 1'b0;
        model_clear();
        test_reset();
        test_single_source();
        test_priority();
        test_mask();
        test_set_clear();
        test_reset_mid_service();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/irq_source_unit.md
Name: irq_source_unit

Overview:
- Peripheral-side end of the core's interrupt handshake: collects N interrupt sources, latches rising edges into a pending register, and arbitrates by fixed priority.
- Drives the single-line request into the core's interrupt controller and consumes that controller's return strobe, which signals that mret completed the handler.
- Clears the served source on return and rearbitrates.
- Sits between the peripheral bus devices and the core top level.

Parameters:
- N_SRC, 16, number of interrupt sources (2..32).
- ID_W, $clog2(N_SRC), width of the source index.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset (asserted at 0).
- src_i  in  N_SRC  interrupt lines, synchronous to clk_i; a rising edge raises an event.
- en_i  in  N_SRC  per-source enable mask; 1 = source may be arbitrated.
- irq_ret_i  in  1  1-cycle strobe from the core: handler returned (mret).
- irq_req_o  out  1  interrupt request to the core.
- irq_id_o  out  ID_W  index of the source being requested/served.
- pending_o  out  N_SRC  pending register, readable by software via the peripheral bus.
- busy_o  out  1  high while a source is in service (REQ state).

Behaviour:
- Reset (rst_i=0, asynchronous): src_q=0, pending=0, state=IDLE, id_q=0. Outputs: irq_req_o=0, irq_id_o=0, pending_o=0, busy_o=0.
- Edge detect: rise = src_i & ~src_q; src_q <= src_i every cycle. Because src_q resets to 0, a line already high at reset release produces one event on the first active edge.
- Pending update, per bit each cycle: pending <= (pending & ~clr) | rise.
  - clr is one-hot at id_q only when state=REQ and irq_ret_i=1.
  - Set wins over clear: a new edge on the served source in the return cycle leaves the bit set.
  - A second edge while the bit is already pending is merged, not counted.
- Arbitration: cand = pending & en_i. The winner is the lowest set index (index 0 has highest priority).
- FSM states IDLE, REQ, GAP:
  - IDLE: if cand != 0, capture the winner into id_q and go to REQ next cycle. A pending bit set by an edge in cycle t is first visible to arbitration in cycle t+1, so irq_req_o rises at t+2.
  - REQ: irq_req_o=1, busy_o=1, id_q frozen. Stay until irq_ret_i=1, then clear pending[id_q] and go to GAP.
  - GAP: irq_req_o=0 for exactly one cycle, then go to IDLE. This guarantees a deasserted cycle so the core controller's in-service state clears before a new request.
- irq_id_o = id_q, registered and stable for the whole of REQ.
- Masking en_i[id_q] during REQ does not abort service; the request stays up until return.
- irq_ret_i in IDLE or GAP is ignored: no pending change, no state change.
- Higher-priority edges arriving during REQ do not preempt. They are arbitrated after GAP.
- Asserting rst_i mid-service drops irq_req_o immediately (asynchronously) and discards all pending events.
- No combinational path from inputs to irq_req_o or irq_id_o; all outputs are register-driven.

Decomposition:
- Shared package irq_pkg: state enum (IDLE, REQ, GAP) and a default N_SRC constant.
- Sub-module irq_prio_enc: a combinational lowest-index priority encoder that outputs the index and a valid flag, parameterised by width. It is reused by future multi-level controllers.
- Edge detect, pending register and FSM stay in the top module.

Test Plan:
- Reset: hold rst_i=0 with src_i=16'hFFFF. Expect all outputs 0. Release reset: pending_o=16'hFFFF after 1 edge, irq_req_o=1 with irq_id_o=0 two cycles later.
- Single source: en_i=16'hFFFF, pulse src_i[5] for 1 cycle at t. Expect pending_o[5]=1 at t+1, irq_req_o=1 and irq_id_o=5 at t+2. Pulse irq_ret_i. Expect pending_o[5]=0, irq_req_o=0 for exactly 1 cycle, then remains 0.
- Priority: raise src 3 and src 9 in the same cycle. Expect service of id 3. After return and GAP, expect irq_req_o=1 with irq_id_o=9. An edge on src 1 raised during service of 3 is served before 9.
- Mask: en_i=16'hFFFE, pulse src 0. Expect pending_o[0]=1 and irq_req_o=0. Set en_i[0]=1: request with id 0 next+1 cycle.
- Simultaneous set/clear: during REQ for id 4, drive a src_i[4] rising edge in the irq_ret_i cycle. Expect pending_o[4] stays 1 and id 4 is re-requested after GAP. Stray irq_ret_i in IDLE causes no change.
- Reset mid-service: assert rst_i=0 asynchronously (between clock edges) during REQ. Expect irq_req_o=0 and pending_o=0 without waiting for a clock edge.
